sa_gemm_nxn: RTL

- Parametrised N x N output-stationary systolic array for signed integer matrix multiply, C = A(NxK) * B(KxN).
- Built-in input skewing, K-length streaming with a valid/ready handshake, a start/busy/done control FSM, and an accumulate-or-clear mode.
- Successor to the fixed 2x2 SA; it sits between the operand-fetch logic and the result writeback in the accelerator datapath.

---
 rtl/sa_gemm_nxn_pkg.sv | 14 +
 rtl/sa_gemm_nxn_pe.sv | 58 +++++
 rtl/sa_gemm_nxn.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sa_gemm_nxn_pkg.sv
// Shared types and default sizing for the N x N output-stationary systolic GEMM array.
package sa_pkg;

    localparam int unsigned SA_N      = 4;
    localparam int unsigned SA_WIDTH  = 8;
    localparam int unsigned SA_ACC    = 32;
    localparam int unsigned SA_KMAX_W = 16;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} sa_state_t;

    typedef logic signed [SA_WIDTH-1:0] operand_t;
    typedef logic signed [SA_ACC-1:0]   acc_t;

endpackage

// File: rtl/sa_gemm_nxn_pe.sv
// One MAC cell: registers a/b with their tags for forwarding and accumulates their product.
module sa_pe
    import sa_pkg::*;
#(
    parameter int unsigned WIDTH = SA_WIDTH,
    parameter int unsigned ACC   = SA_ACC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] a_in,
    input  logic             a_tag_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             b_tag_in,
    output logic [WIDTH-1:0] a_out,
    output logic             a_tag_out,
    output logic [WIDTH-1:0] b_out,
    output logic             b_tag_out,
    output logic [ACC-1:0]   acc
);

    logic [WIDTH-1:0] a_q, b_q;
    logic             a_tag_q, b_tag_q;
    logic [ACC-1:0]   acc_q;
    logic [ACC-1:0]   a_ext, b_ext, prod;

    // Sign-extend before multiplying so the low ACC bits hold the exact signed product.
    assign a_ext = {{(ACC-WIDTH){a_q[WIDTH-1]}}, a_q};
    assign b_ext = {{(ACC-WIDTH){b_q[WIDTH-1]}}, b_q};
    assign prod  = a_ext * b_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            a_tag_q <= 1'b0;
            b_tag_q <= 1'b0;
            acc_q   <= '0;
        end else begin
            a_q     <= a_in;
            b_q     <= b_in;
            a_tag_q <= a_tag_in;
            b_tag_q <= b_tag_in;
            if (clr) begin
                acc_q <= '0;
            end else if (a_tag_q && b_tag_q) begin
                acc_q <= acc_q + prod;
            end
        end
    end

    assign a_out     = a_q;
    assign a_tag_out = a_tag_q;
    assign b_out     = b_q;
    assign b_tag_out = b_tag_q;
    assign acc       = acc_q;

endmodule

// File: rtl/sa_gemm_nxn.sv
// N x N output-stationary systolic array computing C = A * B with built-in input skew,
// valid/ready operand streaming and a start/busy/done control FSM.
module sa_gemm_nxn
    import sa_pkg::*;
#(
    parameter int unsigned N      = SA_N,
    parameter int unsigned WIDTH  = SA_WIDTH,
    parameter int unsigned ACC    = SA_ACC,
    parameter int unsigned KMAX_W = SA_KMAX_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [KMAX_W-1:0]    k_len,
    input  logic                 acc_mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WIDTH-1:0]   a_col,
    input  logic [N*WIDTH-1:0]   b_row,
    output logic                 busy,
    output logic                 done,
    output logic [N*N*ACC-1:0]   acc_out
);

    localparam int unsigned FLUSH_LAST = 2 * N - 2;
    localparam int unsigned FCW        = (N > 1) ? $clog2(2 * N - 1) : 1;

    sa_state_t         state_q, state_d;
    logic [KMAX_W-1:0] k_len_q, beat_cnt_q;
    logic [FCW-1:0]    flush_cnt_q;
    logic              beat, last_beat, flush_end, acc_clr;

    assign beat      = in_valid & in_ready;
    assign last_beat = beat && (beat_cnt_q == k_len_q - KMAX_W'(1));
    assign flush_end = (flush_cnt_q == FCW'(FLUSH_LAST));
    assign acc_clr   = (state_q == IDLE) && start && !acc_mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = (k_len == '0) ? DONE : STREAM;
            STREAM:  if (last_beat) state_d = FLUSH;
            FLUSH:   if (flush_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE:    ;
            STREAM:  begin in_ready = 1'b1; busy = 1'b1; end
            FLUSH:   busy = 1'b1;
            DONE:    begin busy = 1'b1; done = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_len_q     <= '0;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                k_len_q    <= k_len;
                beat_cnt_q <= '0;
            end else if (beat) begin
                beat_cnt_q <= beat_cnt_q + KMAX_W'(1);
            end
            if (state_q == FLUSH) begin
                flush_cnt_q <= flush_cnt_q + FCW'(1);
            end else begin
                flush_cnt_q <= '0;
            end
        end
    end

    // a_fwd[i][j] / b_fwd[i][j] are the operands entering PE[i][j]; index N is the far edge.
    logic [WIDTH-1:0] a_fwd [N][N+1];
    logic             a_tag [N][N+1];
    logic [WIDTH-1:0] b_fwd [N+1][N];
    logic             b_tag [N+1][N];

    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [WIDTH-1:0] a_in, b_in;
        logic             unused_edge;

        // Bubbles carry zero operands so a stray tag could never add garbage.
        assign a_in = beat ? a_col[i*WIDTH +: WIDTH] : '0;
        assign b_in = beat ? b_row[i*WIDTH +: WIDTH] : '0;

        if (i == 0) begin : g_direct
            assign a_fwd[0][0] = a_in;
            assign a_tag[0][0] = beat;
            assign b_fwd[0][0] = b_in;
            assign b_tag[0][0] = beat;
        end else begin : g_line
            logic [WIDTH-1:0] a_line_q [i];
            logic [WIDTH-1:0] b_line_q [i];
            logic             at_q     [i];
            logic             bt_q     [i];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < i; k++) begin
                        a_line_q[k] <= '0;
                        b_line_q[k] <= '0;
                        at_q[k]     <= 1'b0;
                        bt_q[k]     <= 1'b0;
                    end
                end else begin
                    a_line_q[0] <= a_in;
                    b_line_q[0] <= b_in;
                    at_q[0]     <= beat;
                    bt_q[0]     <= beat;
                    for (int k = 1; k < i; k++) begin
                        a_line_q[k] <= a_line_q[k-1];
                        b_line_q[k] <= b_line_q[k-1];
                        at_q[k]     <= at_q[k-1];
                        bt_q[k]     <= bt_q[k-1];
                    end
                end
            end

            assign a_fwd[i][0] = a_line_q[i-1];
            assign a_tag[i][0] = at_q[i-1];
            assign b_fwd[0][i] = b_line_q[i-1];
            assign b_tag[0][i] = bt_q[i-1];
        end

        assign unused_edge = ^{a_fwd[i][N], a_tag[i][N], b_fwd[N][i], b_tag[N][i]};
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            sa_pe #(
                .WIDTH (WIDTH),
                .ACC   (ACC)
            ) u_pe (
                .clk       (clk),
                .rst       (rst),
                .clr       (acc_clr),
                .a_in      (a_fwd[i][j]),
                .a_tag_in  (a_tag[i][j]),
                .b_in      (b_fwd[i][j]),
                .b_tag_in  (b_tag[i][j]),
                .a_out     (a_fwd[i][j+1]),
                .a_tag_out (a_tag[i][j+1]),
                .b_out     (b_fwd[i+1][j]),
                .b_tag_out (b_tag[i+1][j]),
                .acc       (acc_out[(i*N+j)*ACC +: ACC])
            );
        end
    end

endmodule
